// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, receiver state encoding,
// the receiver's state/debug record and the clock-divider helper.
package uart_pkg;

   // Default system clock and line rate. The UART TX side uses these too.
   localparam int DEFAULT_CLK_FREQ = 100_000_000;
   localparam int DEFAULT_BAUD     = 115_200;

   // Receiver state encoding (3 bits)
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      START     = ST_START,
      DATA      = ST_DATA,
      STOP      = ST_STOP,
      WAIT_IDLE = ST_WAIT_IDLE
   } rx_state_t;

   // Receiver control record. The receiver keeps its state in this struct so
   // that state and bit position can be observed as one named signal.
   typedef struct packed {
      rx_state_t  state;
      logic [2:0] bcnt;
   } rx_fsm_t;

   // Clocks per oversample tick, rounded to the nearest integer.
   function automatic int calc_div(input int clk_freq, input int baud, input int os);
      int tick_rate;
      tick_rate = baud * os;
      return (clk_freq + tick_rate / 2) / tick_rate;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: a 0..DIV-1 counter that strobes tick for one
// clock on DIV-1. While en is low the counter is held at 0, so the first tick
// lands exactly DIV clocks after en rises.
module baud_tick_gen #(
   parameter int DIV = 54
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   // Free-running divider while enabled, parked at zero otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!en || cnt == CW'(DIV - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end (LSB first). Synchronises the raw rx pin,
// oversamples it, rejects start-bit glitches and reports framing errors.
//
// Output handshake: rx_valid is a one-cycle strobe with no ready/backpressure;
// rx_data holds the byte from that strobe until the next one, and the consumer
// must take every strobe. frame_err is a one-cycle strobe that never coincides
// with rx_valid and leaves rx_data untouched.
//
// OVERSAMPLE must be even and at least 8; DIV is derived and not overridable.
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter  int CLK_FREQ   = DEFAULT_CLK_FREQ,
   parameter  int BAUD       = DEFAULT_BAUD,
   parameter  int OVERSAMPLE = 16,
   localparam int DIV        = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] SCNT_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);

   logic [1:0]    sync_q;
   logic          rxs;
   logic          tick;
   rx_fsm_t       fsm;
   logic [SW-1:0] scnt;
   logic [7:0]    shreg;

   // Two-flop synchroniser on the asynchronous pin; resets to the idle level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rxs = sync_q[1];

   // Ticks only run during a frame so the sample phase follows the start edge
   baud_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (fsm.state != IDLE),
      .tick  (tick)
   );

   // Frame FSM: start qualification, data shifting, stop check, break wait
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm.state <= IDLE;
         fsm.bcnt  <= '0;
         scnt      <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (fsm.state)
            IDLE: begin
               scnt     <= '0;
               fsm.bcnt <= '0;
               if (!rxs) begin
                  fsm.state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (scnt == SCNT_HALF) begin
                     // Mid start bit: a line already back high was a glitch
                     scnt      <= '0;
                     fsm.bcnt  <= '0;
                     fsm.state <= rxs ? IDLE : DATA;
                  end else begin
                     scnt <= scnt + SW'(1);
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (scnt == SCNT_LAST) begin
                     scnt  <= '0;
                     shreg <= {rxs, shreg[7:1]};
                     if (fsm.bcnt == 3'd7) begin
                        fsm.state <= STOP;
                     end else begin
                        fsm.bcnt <= fsm.bcnt + 3'd1;
                     end
                  end else begin
                     scnt <= scnt + SW'(1);
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (scnt == SCNT_LAST) begin
                     scnt <= '0;
                     if (rxs) begin
                        rx_data   <= shreg;
                        rx_valid  <= 1'b1;
                        fsm.state <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        fsm.state <= WAIT_IDLE;
                     end
                  end else begin
                     scnt <= scnt + SW'(1);
                  end
               end
            end
            WAIT_IDLE: begin
               // A held-low (break) line must return high before a new frame
               if (rxs) begin
                  fsm.state <= IDLE;
               end
            end
            default: begin
               fsm.state <= IDLE;
            end
         endcase
      end
   end

   assign rx_busy = (fsm.state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend. Runs the receiver at 1 Mbit/s so a bit is
// 96 clocks (DIV = 6 at 16x oversampling) and the whole run stays short.
// A frame-level model (queue of expected events with their start cycles)
// is checked against the outputs on every clock.
module tb_uart_rx_frontend;
   import uart_pkg::*;

   localparam int TB_CLK_FREQ = 100_000_000;
   localparam int TB_BAUD     = 1_000_000;
   localparam int TB_OS       = 16;
   localparam int TB_DIV      = 6;               // 100e6 / 16e6 = 6.25 -> 6
   localparam int BIT         = TB_DIV * TB_OS;  // clocks per bit on the line
   localparam int LAT         = (19 * BIT) / 2;  // 9.5 bit times

   // ---------------- clock / reset ----------------
   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       frame_err;
   logic       rx_busy;

   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_frontend #(
      .CLK_FREQ   (TB_CLK_FREQ),
      .BAUD       (TB_BAUD),
      .OVERSAMPLE (TB_OS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   // ---------------- scoreboard state ----------------
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [8:0]  exp_q[$];     // {is_frame_err, byte}
   int unsigned start_q[$];   // cycle at which each frame's start edge was driven
   int unsigned pulse_q[$];   // cycles of observed rx_valid pulses
   logic [7:0]  hold = 8'h00; // byte rx_data must show between pulses
   logic        prev_busy = 1'b0;
   logic [8:0]  ev;
   int unsigned ev_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (reset) begin
         hold      = 8'h00;
         prev_busy = 1'b0;
      end else begin
         if (rx_valid || frame_err) begin
            check("pulse_exclusive", {31'b0, rx_valid & frame_err}, 0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pulse: got rx_valid=%0b frame_err=%0b, expected none (cycle %0d)",
                        rx_valid, frame_err, cyc);
            end else begin
               ev   = exp_q.pop_front();
               ev_t = start_q.pop_front();
               check("pulse_kind", {31'b0, frame_err}, {31'b0, ev[8]});
               check_range("latency", int'(cyc - ev_t), LAT + 2, LAT + 4);
               if (!ev[8]) begin
                  hold = ev[7:0];
                  check("busy_falls_at_pulse", {30'b0, prev_busy, rx_busy}, 32'h2);
                  pulse_q.push_back(cyc);
               end
            end
         end
         check("rx_data", {24'b0, rx_data}, {24'b0, hold});
         prev_busy = rx_busy;
      end
   end

   // ---------------- driver tasks ----------------
   // All drives happen 1 time unit after a rising edge.
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      wait_clk(BIT);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      exp_q.push_back({~stop_ok, stop_ok ? b : 8'h00});
      start_q.push_back(cyc);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      wait_clk(n * BIT);
   endtask

   // ---------------- directed sequence ----------------
   logic [7:0] a5;
   int unsigned p0;

   initial begin
      // Divider helper pinned by hand-computed values
      check("calc_div_default", calc_div(100_000_000, 115_200, 16), 54);
      check("calc_div_os8", calc_div(100_000_000, 115_200, 8), 109);
      check("calc_div_bench", calc_div(TB_CLK_FREQ, TB_BAUD, TB_OS), TB_DIV);

      // Reset state
      reset = 1'b1;
      rx    = 1'b1;
      wait_clk(3);
      check("rst_rx_valid", {31'b0, rx_valid}, 0);
      check("rst_frame_err", {31'b0, frame_err}, 0);
      check("rst_rx_busy", {31'b0, rx_busy}, 0);
      check("rst_rx_data", {24'b0, rx_data}, 0);
      reset = 1'b0;
      idle_bits(2);

      // Single byte
      p0 = pulse_q.size();
      send_frame(8'h80, 1'b1);
      idle_bits(1);
      check("single_count", pulse_q.size() - p0, 1);
      check("single_data", {24'b0, rx_data}, 32'h80);
      check("single_idle", {31'b0, rx_busy}, 0);

      // Back-to-back frames, no idle gap
      p0 = pulse_q.size();
      send_frame(8'h80, 1'b1);
      send_frame(8'h05, 1'b1);
      send_frame(8'hAA, 1'b1);
      idle_bits(2);
      check("b2b_count", pulse_q.size() - p0, 3);
      if (pulse_q.size() - p0 == 3) begin
         check_range("b2b_spacing_1", int'(pulse_q[p0+1] - pulse_q[p0]), 10 * BIT - 1, 10 * BIT + 1);
         check_range("b2b_spacing_2", int'(pulse_q[p0+2] - pulse_q[p0+1]), 10 * BIT - 1, 10 * BIT + 1);
      end
      check("b2b_last_data", {24'b0, rx_data}, 32'hAA);

      // Start-bit glitch of 20 clocks
      p0 = pulse_q.size();
      rx = 1'b0;
      wait_clk(20);
      rx = 1'b1;
      wait_clk(10);
      check("glitch_started", {31'b0, rx_busy}, 1);
      wait_clk(8 * TB_DIV - 30 + 5);
      check("glitch_rejected", {31'b0, rx_busy}, 0);
      idle_bits(1);
      check("glitch_no_pulse", pulse_q.size() - p0, 0);
      send_frame(8'h12, 1'b1);
      idle_bits(1);
      check("after_glitch_data", {24'b0, rx_data}, 32'h12);

      // Framing error followed by a held-low line
      p0 = pulse_q.size();
      send_frame(8'h55, 1'b0);
      rx = 1'b0;
      wait_clk(3 * BIT);
      check("wait_idle_held", {31'b0, rx_busy}, 1);
      check("ferr_data_kept", {24'b0, rx_data}, 32'h12);
      check("ferr_no_valid", pulse_q.size() - p0, 0);
      rx = 1'b1;
      wait_clk(5);
      check("wait_idle_released", {31'b0, rx_busy}, 0);
      idle_bits(1);
      send_frame(8'h3C, 1'b1);
      idle_bits(1);
      check("after_ferr_data", {24'b0, rx_data}, 32'h3C);

      // Extremes
      send_frame(8'h00, 1'b1);
      idle_bits(1);
      check("extreme_00", {24'b0, rx_data}, 32'h00);
      send_frame(8'hFF, 1'b1);
      idle_bits(1);
      check("extreme_ff", {24'b0, rx_data}, 32'hFF);

      // Reset in the middle of data bit 4 of 0xA5
      p0 = pulse_q.size();
      a5 = 8'hA5;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(a5[i]);
      rx = a5[4];
      wait_clk(BIT / 2);
      check("midframe_busy", {31'b0, rx_busy}, 1);
      reset = 1'b1;
      #1;
      check("midrst_rx_valid", {31'b0, rx_valid}, 0);
      check("midrst_frame_err", {31'b0, frame_err}, 0);
      check("midrst_rx_busy", {31'b0, rx_busy}, 0);
      check("midrst_rx_data", {24'b0, rx_data}, 0);
      rx = 1'b1;
      wait_clk(5);
      reset = 1'b0;
      idle_bits(2);
      check("midrst_no_pulse", pulse_q.size() - p0, 0);
      send_frame(8'h5A, 1'b1);
      idle_bits(1);
      check("after_rst_data", {24'b0, rx_data}, 32'h5A);

      idle_bits(2);
      check("all_events_seen", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Serial receiver, 8N1, LSB first, directly upstream of the command parser.
- Turns the raw rx pin into one-cycle rx_valid/rx_data byte strobes that feed the command parser's rx_valid/rx_data inputs without glue logic.
- Oversamples the line, rejects start-bit glitches and flags framing errors.
- Single clock domain (clk); the rx pin is asynchronous and is synchronised inside.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit. Must be even and >= 8.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest (54 at defaults), clocks per sample tick. Derived; do not override.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- rx_valid  output  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  output  8  received byte; stable from the rx_valid pulse until the next pulse.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser flops go to 1 (line idle).
  - state = IDLE; all counters = 0.
  - rx_valid = 0, frame_err = 0, rx_busy = 0, rx_data = 0x00.
- Synchroniser: 2 flops on rx, giving rxs. All logic uses rxs only.
- Tick generator:
  - Counts 0..DIV-1 and emits tick for 1 cycle on DIV-1.
  - Held at 0 in IDLE, so sample phase aligns to the start edge.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rxs==0 -> START; clear sample count (scnt).
  - START: on the tick where scnt==OVERSAMPLE/2-1 (mid start bit):
    - rxs==0 -> DATA; scnt=0, bit count (bcnt)=0.
    - rxs==1 -> IDLE (glitch rejected; no outputs).
  - DATA: on the tick where scnt==OVERSAMPLE-1 (mid data bit):
    - Shift rxs into shreg[7] and shift right, so LSB arrives first.
    - bcnt==7 -> STOP; otherwise bcnt+1.
  - STOP: at mid stop bit:
    - rxs==1: rx_data <= shreg, rx_valid=1 for exactly 1 cycle, -> IDLE.
    - rxs==0: frame_err=1 for 1 cycle, rx_data unchanged, no rx_valid, -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then -> IDLE. Prevents a held-low/break line from producing bytes.
- Timing:
  - Returning to IDLE at mid stop bit lets back-to-back frames be received; the next start edge is detected a half bit later.
  - Latency: rx_valid rises 9.5 bit times (plus 2-3 clk) after the start-bit falling edge on rx.
- rx_valid and frame_err are never high together. Each is registered, never combinational.
- There is no ready/backpressure: the consumer must accept every pulse. The command parser does this.
- Reset mid-frame: immediate return to IDLE; partial byte discarded; no pulse emitted.

Decomposition:
- Package uart_pkg:
  - State encoding localparams (3 bits).
  - Function calc_div(clk_freq, baud, os).
  - Default frequency and baud constants; the UART TX side reuses these.
- Sub-module baud_tick_gen: parameter DIV; inputs clk, reset, en; output tick.

Test Plan:
- Bit period at defaults is 864 clk (8640 ns).
- Single byte: send 0x80 framed 8N1 -> exactly one rx_valid pulse; rx_data=0x80; frame_err stays 0; rx_busy falls at the pulse.
- Back-to-back: 0x80, 0x05, 0xAA sent with no idle gap -> three rx_valid pulses in order with rx_data 0x80, 0x05, 0xAA; pulses spaced 8640 clk ±1.
- Glitch: rx low for 200 ns (20 clk), then high -> no rx_valid and no frame_err; state back to IDLE within 8 ticks. A following 0x12 is then received correctly.
- Framing error: 0x55 with stop bit driven 0, line held low 3 bit times, then 0x3C sent normally ->
  - One frame_err pulse and no rx_valid for the bad frame.
  - rx_data unchanged by the bad frame.
  - WAIT_IDLE held until the line goes high.
  - rx_data=0x3C with one rx_valid afterwards.
- Reset mid-frame: assert reset during bit 4 of 0xA5 -> outputs 0 immediately; no pulse. A subsequent 0x5A gives rx_valid with rx_data=0x5A.
- Extremes: 0x00 and 0xFF -> rx_data 0x00 and 0xFF respectively; no frame_err.
